// File: rtl/period_meter_pkg.sv
// period_meter_pkg: widths, measurement limits and state encoding for period_meter
package period_meter_pkg;
  localparam int CNT_W = 6;
  localparam int DIV_W = 5;
  localparam logic [CNT_W-1:0] P_MIN = 6'd2;
  localparam logic [CNT_W-1:0] P_MAX = 6'd32;
  localparam logic [CNT_W-1:0] CNT_SAT = 6'd63;
  localparam logic [CNT_W-1:0] P_STALL = 6'd62;
  typedef enum logic {UNARMED, ARMED} state_t;
endpackage

// File: rtl/rise_detect.sv
// rise_detect: one-cycle strobe on a rising edge of a same-domain input
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic rise
);
  logic in_q;
  // previous-cycle copy of the input
  always_ff @(posedge clk)
    if (reset) in_q <= 1'b0;
    else in_q <= in;
  assign rise = in & ~in_q;
endmodule

// File: rtl/period_meter.sv
// period_meter: recovers a divider setting from the period of a same-domain square wave
module period_meter
  import period_meter_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  output logic [DIV_W-1:0] div,
  output logic [CNT_W-1:0] high,
  output logic             valid,
  output logic             err,
  output logic             locked,
  output logic             stall
);
  logic rise, prev_valid, meas_ok, meas_err, stall_hit;
  logic [CNT_W-1:0] cnt, hcnt, p_m1;
  state_t state, state_nx;
  rise_detect u_rise (.clk(clk), .reset(reset), .in(in), .rise(rise));
  // period and high-phase counters, restarted by each rising edge
  always_ff @(posedge clk)
    if (reset) begin
      cnt <= '0;
      hcnt <= '0;
    end else if (rise) begin
      cnt <= 6'd1;
      hcnt <= 6'd1;
    end else begin
      cnt <= (cnt == CNT_SAT) ? cnt : cnt + 6'd1;
      hcnt <= (in && hcnt != CNT_SAT) ? hcnt + 6'd1 : hcnt;
    end
  // state register
  always_ff @(posedge clk)
    if (reset) state <= UNARMED;
    else state <= state_nx;
  // classify the closing period and pick the next state; a rise beats a stall
  always_comb begin
    p_m1 = cnt - 6'd1;
    stall_hit = !rise && cnt == P_STALL;
    meas_ok = state == ARMED && rise && cnt >= P_MIN && cnt <= P_MAX;
    meas_err = state == ARMED && rise && cnt > P_MAX && cnt < CNT_SAT;
    state_nx = rise ? ARMED : stall_hit ? UNARMED : state;
  end
  // result, strobe, lock and stall registers
  always_ff @(posedge clk)
    if (reset) begin
      div <= '0;
      high <= '0;
      valid <= 1'b0;
      err <= 1'b0;
      locked <= 1'b0;
      stall <= 1'b0;
      prev_valid <= 1'b0;
    end else begin
      valid <= meas_ok;
      err <= meas_err;
      if (meas_ok) begin
        div <= p_m1[DIV_W-1:0];
        high <= hcnt;
        locked <= prev_valid && div == p_m1[DIV_W-1:0] && high == hcnt;
        prev_valid <= 1'b1;
      end else if (meas_err || stall_hit) begin
        locked <= 1'b0;
        prev_valid <= 1'b0;
      end
      if (rise) stall <= 1'b0;
      else if (stall_hit) stall <= 1'b1;
    end
endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: directed checks of period_meter measurement, lock, error and stall
module tb_period_meter;
  logic clk = 1'b0, reset = 1'b0, in = 1'b0;
  logic [4:0] div, s_div;
  logic [5:0] high, s_high;
  logic valid, err, locked, stall;
  logic s_valid, s_err, s_locked, s_stall;
  int s_extra;
  int checks = 0, failures = 0;
  period_meter dut (.clk(clk), .reset(reset), .in(in), .div(div), .high(high),
                    .valid(valid), .err(err), .locked(locked), .stall(stall));
  always #5 clk = ~clk;
  task automatic cyc(input logic v);
    in = v;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    in = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask
  task automatic wave(input int hi, input int lo);
    cyc(1'b1);
    s_div = div;
    s_high = high;
    s_valid = valid;
    s_err = err;
    s_locked = locked;
    s_stall = stall;
    s_extra = 0;
    for (int i = 1; i < hi + lo; i++) begin
      cyc(i < hi);
      s_extra += int'(valid | err);
    end
  endtask
  task automatic test_reset();
    reset = 1'b1;
    in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    if ({div, high, valid, err, locked, stall} !== 15'd0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", {div, high, valid, err, locked, stall}); end checks++;
  endtask
  task automatic test_basic();
    do_reset();
    wave(3, 3);
    if (s_valid !== 1'b0) begin failures++; $display("FAIL basic_arm_valid got=%b exp=0", s_valid); end checks++;
    wave(3, 3);
    if (s_valid !== 1'b1) begin failures++; $display("FAIL basic_valid2 got=%b exp=1", s_valid); end checks++;
    if (s_div !== 5'd5) begin failures++; $display("FAIL basic_div2 got=%0d exp=5", s_div); end checks++;
    if (s_high !== 6'd3) begin failures++; $display("FAIL basic_high2 got=%0d exp=3", s_high); end checks++;
    if (s_locked !== 1'b0) begin failures++; $display("FAIL basic_locked2 got=%b exp=0", s_locked); end checks++;
    wave(3, 3);
    if (s_valid !== 1'b1) begin failures++; $display("FAIL basic_valid3 got=%b exp=1", s_valid); end checks++;
    if (s_locked !== 1'b1) begin failures++; $display("FAIL basic_locked3 got=%b exp=1", s_locked); end checks++;
    if (s_extra !== 0) begin failures++; $display("FAIL basic_strobe_len got=%0d exp=0", s_extra); end checks++;
  endtask
  task automatic test_period2();
    do_reset();
    wave(1, 1);
    wave(1, 1);
    if (s_valid !== 1'b1 || s_div !== 5'd1 || s_high !== 6'd1 || s_locked !== 1'b0) begin failures++; $display("FAIL p2_first got v=%b d=%0d h=%0d l=%b exp v=1 d=1 h=1 l=0", s_valid, s_div, s_high, s_locked); end checks++;
    wave(1, 1);
    if (s_valid !== 1'b1 || s_div !== 5'd1 || s_high !== 6'd1 || s_locked !== 1'b1) begin failures++; $display("FAIL p2_second got v=%b d=%0d h=%0d l=%b exp v=1 d=1 h=1 l=1", s_valid, s_div, s_high, s_locked); end checks++;
    wave(1, 1);
    if (s_valid !== 1'b1 || s_locked !== 1'b1) begin failures++; $display("FAIL p2_third got v=%b l=%b exp v=1 l=1", s_valid, s_locked); end checks++;
  endtask
  task automatic test_err();
    do_reset();
    wave(16, 16);
    wave(16, 16);
    if (s_valid !== 1'b1 || s_div !== 5'd31 || s_high !== 6'd16) begin failures++; $display("FAIL err_p32 got v=%b d=%0d h=%0d exp v=1 d=31 h=16", s_valid, s_div, s_high); end checks++;
    wave(16, 24);
    if (s_locked !== 1'b1) begin failures++; $display("FAIL err_p32_lock got=%b exp=1", s_locked); end checks++;
    wave(16, 16);
    if (s_err !== 1'b1 || s_valid !== 1'b0) begin failures++; $display("FAIL err_p40_strobe got e=%b v=%b exp e=1 v=0", s_err, s_valid); end checks++;
    if (s_locked !== 1'b0) begin failures++; $display("FAIL err_p40_locked got=%b exp=0", s_locked); end checks++;
    if (s_div !== 5'd31 || s_high !== 6'd16) begin failures++; $display("FAIL err_p40_hold got d=%0d h=%0d exp d=31 h=16", s_div, s_high); end checks++;
    if (s_extra !== 0) begin failures++; $display("FAIL err_strobe_len got=%0d exp=0", s_extra); end checks++;
    wave(1, 1);
    if (s_valid !== 1'b1 || s_locked !== 1'b0 || s_div !== 5'd31) begin failures++; $display("FAIL err_after got v=%b l=%b d=%0d exp v=1 l=0 d=31", s_valid, s_locked, s_div); end checks++;
  endtask
  task automatic test_stall();
    do_reset();
    wave(3, 3);
    wave(3, 3);
    cyc(1'b1);
    if (valid !== 1'b1 || locked !== 1'b1) begin failures++; $display("FAIL stall_pre got v=%b l=%b exp v=1 l=1", valid, locked); end checks++;
    for (int k = 1; k <= 70; k++) begin
      cyc(1'b0);
      if (k == 61) begin
        if (stall !== 1'b0 || locked !== 1'b1) begin failures++; $display("FAIL stall_edge61 got s=%b l=%b exp s=0 l=1", stall, locked); end checks++;
      end
      if (k == 62) begin
        if (stall !== 1'b1 || locked !== 1'b0) begin failures++; $display("FAIL stall_edge62 got s=%b l=%b exp s=1 l=0", stall, locked); end checks++;
      end
    end
    if (stall !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL stall_hold got s=%b e=%b exp s=1 e=0", stall, err); end checks++;
    wave(3, 3);
    if (s_stall !== 1'b0 || s_valid !== 1'b0 || s_err !== 1'b0) begin failures++; $display("FAIL stall_clear got s=%b v=%b e=%b exp s=0 v=0 e=0", s_stall, s_valid, s_err); end checks++;
    wave(3, 3);
    if (s_valid !== 1'b1 || s_div !== 5'd5 || s_locked !== 1'b0) begin failures++; $display("FAIL stall_after got v=%b d=%0d l=%b exp v=1 d=5 l=0", s_valid, s_div, s_locked); end checks++;
  endtask
  task automatic test_mid_reset();
    do_reset();
    wave(3, 3);
    wave(3, 3);
    cyc(1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    if ({div, high, valid, err, locked, stall} !== 15'd0) begin failures++; $display("FAIL mid_reset_outputs got=%h exp=0", {div, high, valid, err, locked, stall}); end checks++;
    wave(3, 3);
    if (s_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_arm got=%b exp=0", s_valid); end checks++;
    wave(3, 3);
    if (s_valid !== 1'b1 || s_div !== 5'd5 || s_locked !== 1'b0) begin failures++; $display("FAIL mid_reset_meas got v=%b d=%0d l=%b exp v=1 d=5 l=0", s_valid, s_div, s_locked); end checks++;
  endtask
  task automatic test_switch();
    do_reset();
    wave(3, 3);
    wave(4, 4);
    if (s_valid !== 1'b1 || s_div !== 5'd5 || s_high !== 6'd3) begin failures++; $display("FAIL sw_p6 got v=%b d=%0d h=%0d exp v=1 d=5 h=3", s_valid, s_div, s_high); end checks++;
    wave(4, 4);
    if (s_valid !== 1'b1 || s_div !== 5'd7 || s_high !== 6'd4 || s_locked !== 1'b0) begin failures++; $display("FAIL sw_p8_first got v=%b d=%0d h=%0d l=%b exp v=1 d=7 h=4 l=0", s_valid, s_div, s_high, s_locked); end checks++;
    wave(1, 1);
    if (s_valid !== 1'b1 || s_div !== 5'd7 || s_locked !== 1'b1) begin failures++; $display("FAIL sw_p8_second got v=%b d=%0d l=%b exp v=1 d=7 l=1", s_valid, s_div, s_locked); end checks++;
  endtask
  initial begin
    test_reset();
    test_basic();
    test_period2();
    test_err();
    test_stall();
    test_mid_reset();
    test_switch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
